// File: rtl/sram_arbiter.sv
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Two-master arbiter for a single async SRAM (8-bit data).
//            Port A is the CPU bus and port B a secondary master such as a
//            loader or DMA. The block sequences CS/OE/WE with WAIT_CYCLES
//            extra access cycles and returns a one-cycle ack to the owner.
//            Optional macro SRAM_ARB_RR_EN selects round-robin arbitration;
//            without it, port A wins every tie.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sram_arbiter #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_a_cs,
    input  logic              i_a_we,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [7:0]        i_a_dat,
    output logic [7:0]        o_a_dat,
    output logic              o_a_ack,
    input  logic              i_b_cs,
    input  logic              i_b_we,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [7:0]        i_b_dat,
    output logic [7:0]        o_b_dat,
    output logic              o_b_ack,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [7:0]        o_sram_dat,
    input  logic [7:0]        i_sram_dat,
    output logic              o_sram_dat_oe,
    output logic              o_sram_cs_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n,
    output logic              o_grant_b
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] c_wait = 4'(WAIT_CYCLES);

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [3:0] r_cnt;
    logic       r_we;

    logic w_any_req;
    logic w_win_b;
    logic w_sel_we;
    logic w_we_eff;
    logic w_grant;
    logic w_last_access;

    logic w_cs_n;
    logic w_oe_n;
    logic w_we_n;
    logic w_dat_oe;
    logic w_a_ack;
    logic w_b_ack;

    assign w_any_req     = i_a_cs | i_b_cs;
    assign w_grant       = (r_state == S_IDLE) && w_any_req;
    assign w_last_access = (r_state == S_ACCESS) && (r_cnt == 4'd0);
    assign w_sel_we      = w_win_b ? i_b_we : i_a_we;

`ifdef SRAM_ARB_RR_EN
    // Priority flag: 1 means port B wins the next tie.
    logic r_prio_b;

    // Tie goes to the port that was not granted last.
    always_comb begin
        w_win_b = i_b_cs;
        if (i_a_cs && i_b_cs) begin
            w_win_b = r_prio_b;
        end
    end

    // Hand priority to the other port on every grant.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_prio_b <= 1'b0;
        end else if (w_grant) begin
            r_prio_b <= ~w_win_b;
        end
    end
`else
    // Fixed priority: the CPU port always wins a tie.
    always_comb begin
        w_win_b = i_b_cs & ~i_a_cs;
    end
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> SETUP -> ACCESS (counted) -> DONE -> IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_state_next = S_SETUP;
            S_SETUP:  w_state_next = S_ACCESS;
            S_ACCESS: if (r_cnt == 4'd0) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Strobe values for the state being entered, so the pins are registered.
    always_comb begin
        w_we_eff = (r_state == S_IDLE) ? w_sel_we : r_we;
        w_cs_n   = 1'b1;
        w_oe_n   = 1'b1;
        w_we_n   = 1'b1;
        w_dat_oe = 1'b0;
        w_a_ack  = 1'b0;
        w_b_ack  = 1'b0;
        case (w_state_next)
            S_SETUP: begin
                w_cs_n = 1'b0;
                if (w_we_eff) w_dat_oe = 1'b1;
                else          w_oe_n   = 1'b0;
            end
            S_ACCESS: begin
                w_cs_n = 1'b0;
                if (w_we_eff) begin
                    w_we_n   = 1'b0;
                    w_dat_oe = 1'b1;
                end else begin
                    w_oe_n = 1'b0;
                end
            end
            S_DONE: begin
                w_cs_n   = 1'b0;
                w_dat_oe = w_we_eff;
                w_a_ack  = ~o_grant_b;
                w_b_ack  = o_grant_b;
            end
            default: ;
        endcase
    end

    // ACCESS down-counter, loaded while in SETUP.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_cnt <= 4'd0;
        end else if (r_state == S_SETUP) begin
            r_cnt <= c_wait;
        end else if ((r_state == S_ACCESS) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Registered pins, request latching at grant, read-data capture.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_sram_cs_n   <= 1'b1;
            o_sram_oe_n   <= 1'b1;
            o_sram_we_n   <= 1'b1;
            o_sram_dat_oe <= 1'b0;
            o_a_ack       <= 1'b0;
            o_b_ack       <= 1'b0;
            o_sram_addr   <= '0;
            o_sram_dat    <= 8'h00;
            o_a_dat       <= 8'h00;
            o_b_dat       <= 8'h00;
            o_grant_b     <= 1'b0;
            r_we          <= 1'b0;
        end else begin
            o_sram_cs_n   <= w_cs_n;
            o_sram_oe_n   <= w_oe_n;
            o_sram_we_n   <= w_we_n;
            o_sram_dat_oe <= w_dat_oe;
            o_a_ack       <= w_a_ack;
            o_b_ack       <= w_b_ack;
            if (w_grant) begin
                o_sram_addr <= w_win_b ? i_b_addr : i_a_addr;
                o_sram_dat  <= w_win_b ? i_b_dat : i_a_dat;
                r_we        <= w_sel_we;
                o_grant_b   <= w_win_b;
            end
            if (w_last_access && !r_we) begin
                if (o_grant_b) o_b_dat <= i_sram_dat;
                else           o_a_dat <= i_sram_dat;
            end
        end
    end

endmodule

`default_nettype wire
